// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths, defaults and FSM encoding for the register-file write arbiter.
package regfile_wr_arbiter_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_AW         = 5;
    localparam int unsigned NREG           = 32;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // StIdle: result buffer empty; StHold: buffer holds one MDU result.
    typedef enum logic [0:0] {
        StIdle,
        StHold
    } arb_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations plus ID-stage hazard check.
module reg_scoreboard
    import regfile_wr_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    input  logic [REG_AW-1:0] chk_rd,
    input  logic              starve,
    output logic              stall,
    output logic [NREG-1:0]   busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // Hazard lookup works only on registered busy bits, so no loop through stall.
    assign stall = busy_q[chk_rs1] | busy_q[chk_rs2] | (iss_valid & busy_q[chk_rd]) | starve;
    assign busy  = busy_q;

    // Next busy vector: clear on drain, set on accepted issue; set wins on collision.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid && (iss_rd != '0) && !stall) begin
            set_mask[iss_rd] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_rd] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // Busy register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between WB (priority) and a
// one-entry MDU result buffer, with starvation-driven stall and scoreboard.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              mdu_valid,
    input  logic [REG_AW-1:0] mdu_rd,
    input  logic [XLEN-1:0]   mdu_data,
    output logic              mdu_ready,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              stall,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_ws,
    output logic [XLEN-1:0]   rf_wr_data,
    output logic [NREG-1:0]   busy
);

    // STARVE_MAX is assumed to be at least 1.
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    arb_state_e        state_q;
    logic [REG_AW-1:0] buf_rd_q;
    logic [XLEN-1:0]   buf_data_q;
    logic [CntW-1:0]   cnt_q;
    logic              port_free;
    logic              drain;
    logic              starve;

    // Writes to x0 never claim the port, so they cannot block a drain either.
    assign port_free = !(wb_wr_en && (wb_rd != '0));
    assign drain     = (state_q == StHold) && port_free;
    assign starve    = (cnt_q == CntMax);
    assign mdu_ready = (state_q == StIdle);

    // FSM, result buffer and registered write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            rf_wr_en   <= 1'b0;
            rf_ws      <= '0;
            rf_wr_data <= '0;
        end else begin
            if (!port_free) begin
                rf_wr_en   <= 1'b1;
                rf_ws      <= wb_rd;
                rf_wr_data <= wb_data;
            end else if (drain && (buf_rd_q != '0)) begin
                rf_wr_en   <= 1'b1;
                rf_ws      <= buf_rd_q;
                rf_wr_data <= buf_data_q;
            end else begin
                // A drained rd=0 result is dropped here without a write.
                rf_wr_en <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (mdu_valid) begin
                        buf_rd_q   <= mdu_rd;
                        buf_data_q <= mdu_data;
                        state_q    <= StHold;
                    end
                end
                StHold: begin
                    if (port_free) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Consecutive blocked HOLD cycles, saturating at STARVE_MAX.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if ((state_q == StIdle) || drain) begin
            cnt_q <= '0;
        end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    reg_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .clr_en    (drain),
        .clr_rd    (buf_rd_q),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rd    (chk_rd),
        .starve    (starve),
        .stall     (stall),
        .busy      (busy)
    );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed, table-driven bench for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        reset;
    logic        wb_wr_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        stall;
    logic        rf_wr_en;
    logic [4:0]  rf_ws;
    logic [31:0] rf_wr_data;
    logic [31:0] busy;

    int total;
    int bad;

    regfile_wr_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_wr_en   (wb_wr_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mdu_valid  (mdu_valid),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rd     (chk_rd),
        .stall      (stall),
        .rf_wr_en   (rf_wr_en),
        .rf_ws      (rf_ws),
        .rf_wr_data (rf_wr_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied before an edge; expected outputs sampled 1 time unit after it.
    typedef struct {
        logic        rst_n;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  crd;
        logic        e_wen;
        logic [4:0]  e_ws;
        logic [31:0] e_data;
        logic        e_rdy;
        logic        e_stl;
        logic [31:0] e_busy;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset     = v.rst_n;
        wb_wr_en  = v.wb_en;
        wb_rd     = v.wb_rd;
        wb_data   = v.wb_data;
        mdu_valid = v.mv;
        mdu_rd    = v.mrd;
        mdu_data  = v.mdata;
        iss_valid = v.iv;
        iss_rd    = v.ird;
        chk_rs1   = v.rs1;
        chk_rs2   = v.rs2;
        chk_rd    = v.crd;
    endtask

    task automatic idle_inputs();
        reset = 1'b1; wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        reset = 1'b0;

        //          rst  wb   wbrd   wbdata         mv   mrd    mdata          iv   ird
        //          rs1   rs2   crd    | wen  ws     data           rdy  stl  busy
        vecs[0]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0};
        // WB only
        vecs[1]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        // Issue rd=7, then RAW on x7 until the MDU result drains
        vecs[3]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h80};
        // Stalled issue of x8 must not set busy[8]
        vecs[4]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b1, 5'd8,
                     5'd7, 5'd0, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 32'h80};
        vecs[5]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd7, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1234, 1'b1, 1'b0, 32'h0};
        // WB x9 collides with buffered x10: x9 first, x10 next edge
        vecs[6]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hAAAA0010, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd7, 32'h1234, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd10, 32'hAAAA0010, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd10, 32'hAAAA0010, 1'b1, 1'b0, 32'h0};
        // MDU x3 starved by continuous WB x4; stall after 4 blocked HOLD cycles
        vecs[10] = '{1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h45, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 5'd4, 32'h46, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h46, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 5'd4, 32'h47, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h47, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b1, 5'd4, 32'h48, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h48, 1'b0, 1'b1, 32'h0};
        vecs[15] = '{1'b1, 1'b1, 5'd4, 32'h49, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h49, 1'b0, 1'b1, 32'h0};
        vecs[16] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 32'h0};
        // WB to x0 is not a write
        vecs[17] = '{1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 32'h33, 1'b1, 1'b0, 32'h0};
        // Issue x0 and MDU result x0: no busy, no write
        vecs[18] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5, 1'b1, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 32'h33, 1'b0, 1'b0, 32'h0};
        vecs[19] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 32'h33, 1'b1, 1'b0, 32'h0};
        // Set and clear of x7 on the same edge: set wins
        vecs[20] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 32'h33, 1'b1, 1'b0, 32'h80};
        vecs[21] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 32'h33, 1'b0, 1'b0, 32'h80};
        vecs[22] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                     5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 32'h80};
        // WAW check on chk_rd stalls and blocks issue of x9
        vecs[23] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9,
                     5'd0, 5'd0, 5'd7, 1'b0, 5'd7, 32'h77, 1'b1, 1'b1, 32'h80};
        // Reset during HOLD with busy[12] set
        vecs[24] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd7, 32'h77, 1'b1, 1'b0, 32'h1080};
        vecs[25] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd7, 32'h77, 1'b0, 1'b0, 32'h1080};
        vecs[26] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[27] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            tick();
            chk("rf_wr_en", i, 32'(rf_wr_en), 32'(vecs[i].e_wen));
            chk("rf_ws", i, 32'(rf_ws), 32'(vecs[i].e_ws));
            chk("rf_wr_data", i, rf_wr_data, vecs[i].e_data);
            chk("mdu_ready", i, 32'(mdu_ready), 32'(vecs[i].e_rdy));
            chk("stall", i, 32'(stall), 32'(vecs[i].e_stl));
            chk("busy", i, busy, vecs[i].e_busy);
        end

        // Offer held during HOLD is not captured until the buffer frees up.
        @(negedge clk);
        idle_inputs();
        mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h66;
        wb_wr_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h4A;
        tick();
        chk("hold_rdy", 100, 32'(mdu_ready), 32'd0);
        @(negedge clk);
        mdu_rd = 5'd11; mdu_data = 32'hBB;
        tick();
        chk("hold_ws", 101, 32'(rf_ws), 32'd4);
        chk("hold_rdy", 101, 32'(mdu_ready), 32'd0);
        @(negedge clk);
        wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
        tick();
        chk("drain6_ws", 102, 32'(rf_ws), 32'd6);
        chk("drain6_data", 102, rf_wr_data, 32'h66);
        chk("drain6_rdy", 102, 32'(mdu_ready), 32'd1);
        tick();
        chk("accept11_wen", 103, 32'(rf_wr_en), 32'd0);
        chk("accept11_rdy", 103, 32'(mdu_ready), 32'd0);
        @(negedge clk);
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        begin
            int n;
            n = 0;
            while (!(rf_wr_en && rf_ws == 5'd11) && n < 5) begin
                tick();
                n++;
            end
            chk("drain11_seen", 104, 32'(rf_wr_en && rf_ws == 5'd11), 32'd1);
            chk("drain11_data", 104, rf_wr_data, 32'hBB);
            chk("drain11_lat", 104, 32'(n), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 4, consecutive HOLD cycles before stall is forced.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 wb_wr_en / wb_rd / wb_data  in  1/5/32  pipeline WB-stage write request.
REQ-005 mdu_valid / mdu_rd / mdu_data  in  1/5/32  multi-cycle-unit result offer.
REQ-006 mdu_ready  out  1  result-buffer slot free.
REQ-007 iss_valid / iss_rd  in  1/5  long-latency op issued from ID this cycle.
REQ-008 chk_rs1 / chk_rs2 / chk_rd  in  5 each  ID-stage operands to hazard-check.
REQ-009 stall  out  1  freeze IF/ID, insert bubble.
REQ-010 rf_wr_en / rf_ws / rf_wr_data  out  1/5/32  register-file write port, registered.
REQ-011 busy  out  32  scoreboard: pending long-latency destination per register.

Function
REQ-012 FSM states: IDLE (buffer empty), HOLD (buffer full).
REQ-013 mdu_ready SHALL be 1 exactly in IDLE; mdu_valid&&mdu_ready at an edge captures rd/data and enters HOLD.
REQ-014 WB has strict priority: at each edge, if wb_wr_en && wb_rd!=0, rf_* load {1, wb_rd, wb_data}.
REQ-015 Port free = !(wb_wr_en && wb_rd!=0); in HOLD with port free, rf_* load {1, buf_rd, buf_data}, FSM returns to IDLE.
REQ-016 With neither source writing, rf_wr_en loads 0; rf_ws/rf_wr_data hold.
REQ-017 Writes to x0 from either source SHALL never reach rf_wr_en=1; an MDU result with rd=0 is discarded on drain (IDLE, no write).
REQ-018 Latency: MDU accept at edge N, earliest rf_wr_en from it after edge N+1; WB request to rf_wr_en: one edge.
REQ-019 busy[iss_rd] set at edge when iss_valid && iss_rd!=0 && !stall.
REQ-020 busy[buf_rd] cleared at the drain edge of REQ-015; same-index set and clear at one edge: set wins.
REQ-021 busy[0] SHALL be constant 0.
REQ-022 stall = busy[chk_rs1] | busy[chk_rs2] | (iss_valid & busy[chk_rd]) | starve, combinational from registered state.
REQ-023 Starve counter counts consecutive HOLD cycles with port not free, saturates at STARVE_MAX; starve = (cnt==STARVE_MAX); counter zeroed on drain or in IDLE.
REQ-024 Stall release occurs in the cycle rf_wr_en presents the MDU result; the register file's write bypass supplies the value to ID.
REQ-025 mdu_valid while HOLD: no capture, offer held by producer unchanged until accepted.

Reset
REQ-026 reset==0 at an edge: FSM IDLE, busy=0, starve counter 0, rf_wr_en=0, rf_ws=0, rf_wr_data=0; mdu_ready=1, stall=0 after that edge.
REQ-027 Reset during HOLD discards the buffered result without writing it.

Structure
REQ-028 Shared package: XLEN=32, REG_AW=5, NREG=32, STARVE_MAX default, FSM state enum.
REQ-029 One sub-module: reg_scoreboard (busy vector set/clear/lookup, hazard compare).
REQ-030 Write-port mux, FSM, buffer and starve counter in top level; no latches, single always-block per register group.

Verification
REQ-031 WB only: wb_wr_en=1, rd=5, data=0xDEADBEEF -> next cycle rf_wr_en=1, rf_ws=5, rf_wr_data=0xDEADBEEF.
REQ-032 Issue rd=7, then chk_rs1=7 -> stall=1 until MDU result (rd=7, 0x1234) drains; in drain cycle rf_ws=7, stall=0, busy[7]=0.
REQ-033 MDU rd=3 accepted while WB writes rd=4 every cycle -> stall rises after 4 HOLD cycles; first free cycle writes x3, mdu_ready returns to 1.
REQ-034 Simultaneous WB rd=9 and buffered MDU rd=10 -> x9 written first, x10 next edge; no write lost.
REQ-035 iss_valid rd=0 and MDU result rd=0 -> busy stays 0, rf_wr_en never 1, stall 0.
REQ-036 reset low during HOLD with busy[12]=1 -> after edge busy=0, IDLE, rf_wr_en=0, no x12 write follows.
